maze_game_sequencer: RTL and testbench
======================================

// Module: maze_game_sequencer
// PURPOSE
//  Top-level game controller for the memory-maze. Sequences MENU -> SHOW_MAP -> PLAYING -> LOST/WON,
//  owns player position, and validates each move against one map-ROM row (registered ROM, 1-cycle read).
//  Feeds game_state, map_visible and player_x/y to the VGA renderer.
// PARAMETERS
//  MAP_W      30       map columns; map_row bit i = column i (1 = wall)
//  MAP_H      21       map rows; ROM depth
//  START_X/Y  0 / 0    player cell after reset and on return to menu
//  GOAL_X/Y   29 / 20  cell that wins the game
//  SHOW_EASY  100_000_000  map-visible cycles, easy
//  SHOW_MED   50_000_000   map-visible cycles, medium
//  SHOW_HARD  25_000_000   map-visible cycles, hard
//  LIVES      3        starting lives (used only with MAZE_LIVES_EN)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high
//  btn_up/down/left/right/center  in  1 each  debounced single-cycle pulses
//  map_addr     out  5       ROM row address ($clog2(MAP_H))
//  map_row      in   MAP_W   ROM data, valid one cycle after map_addr
//  game_state   out  4       one-hot: 0001 MENU, 0010 GAME, 0100 LOST, 1000 WON
//  menu_sel     out  3       one-hot: 001 start, 010 difficulty, 100 instructions
//  in_instr     out  1       instructions page shown
//  difficulty   out  3       one-hot: 001 easy, 010 medium, 100 hard
//  map_visible  out  1       renderer draws walls
//  player_x/y   out  8 each  player cell
//  lives_left   out  2       remaining lives (constant LIVES without macro)
// BEHAVIOUR
//  Reset: MENU, menu_sel=001, in_instr=0, difficulty=001, map_visible=1, player=START, map_addr=0,
//   lives_left=LIVES, all counters 0, move FSM IDLE. Reset wins over any simultaneous button.
//  MENU: up/down rotate menu_sel (up: 001->100->010->001; down reverse); up beats down.
//   center: start -> GAME/SHOW_MAP, counter=0; difficulty -> rotate 001->010->100->001; instructions -> in_instr=1.
//   While in_instr=1 only center is honoured (clears in_instr).
//  SHOW_MAP: map_visible=1, counter increments each cycle; at count==SHOW_x-1 (per latched difficulty)
//   -> PLAYING next cycle, map_visible=0, counter=0. Buttons ignored. difficulty frozen in GAME.
//  PLAYING move FSM IDLE->FETCH->CHECK->IDLE (3 cycles per move):
//   IDLE: one direction pulse accepted; priority up>down>left>right; others same cycle dropped.
//    Target off-map (x=0 left, x=MAP_W-1 right, y=0 up, y=MAP_H-1 down) -> ignored, stay IDLE.
//   FETCH: map_addr<=target_y. CHECK: sample map_row[target_x].
//    clear -> player<=target; target==GOAL -> WON. wall -> player unchanged, hit handling below.
//   Buttons arriving in FETCH/CHECK are dropped (no queue).
//  LOST/WON: player frozen, map_visible=1; center -> MENU, player=START, lives=LIVES, menu_sel=001.
//  Reset mid-move aborts FSM; no position update.
// CONFIGURATION
//  MAZE_LIVES_EN defined: wall hit decrements lives_left; becomes 0 -> LOST, else stay PLAYING.
//  MAZE_LIVES_EN undefined: first wall hit -> LOST; lives_left tied to LIVES.
// TESTING (SHOW_* overridden to 8/4/2 in bench)
//  reset; down,center(->difficulty),center x2 -> difficulty=100; up,center -> GAME, map_visible=0 after 2 cycles.
//  PLAYING at (0,0), map_row[1]=0, btn_right -> map_addr=0 in FETCH, player_x=1 three cycles after pulse.
//  PLAYING at (0,0), btn_left -> no fetch, player stays (0,0); btn_up+btn_right same cycle -> up ignored (edge)? no: up wins, dropped.
//  wall at target, macro off -> game_state=0100 after CHECK; center -> 0001, player=(0,0).
//  MAZE_LIVES_EN, 3 wall hits -> lives 2,1 then LOST on third; player never moves.
//  move into (29,20) clear -> game_state=1000; reset asserted during FETCH -> MENU, player=START.

Source files
------------

// File: rtl/maze_game_sequencer.sv
// Memory-maze game controller: menu, timed map preview, move validation against a registered map ROM.
// Optional MAZE_LIVES_EN: wall hits spend lives instead of ending the game at once.
module maze_game_sequencer #(
    parameter int MAP_W     = 30,
    parameter int MAP_H     = 21,
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int GOAL_X    = 29,
    parameter int GOAL_Y    = 20,
    parameter int SHOW_EASY = 100_000_000,
    parameter int SHOW_MED  = 50_000_000,
    parameter int SHOW_HARD = 25_000_000,
    parameter int LIVES     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_btn_up,
    input  logic                     i_btn_down,
    input  logic                     i_btn_left,
    input  logic                     i_btn_right,
    input  logic                     i_btn_center,
    output logic [$clog2(MAP_H)-1:0] o_map_addr,
    input  logic [MAP_W-1:0]         i_map_row,
    output logic [3:0]               o_game_state,
    output logic [2:0]               o_menu_sel,
    output logic                     o_in_instr,
    output logic [2:0]               o_difficulty,
    output logic                     o_map_visible,
    output logic [7:0]               o_player_x,
    output logic [7:0]               o_player_y,
    output logic [1:0]               o_lives_left,
    output logic [2:0]               o_dbg_phase,
    output logic [1:0]               o_dbg_move
);

    localparam int AW = $clog2(MAP_H);
    localparam int XW = $clog2(MAP_W);
    localparam int SHOW_MAX = (SHOW_EASY > SHOW_MED)
        ? ((SHOW_EASY > SHOW_HARD) ? SHOW_EASY : SHOW_HARD)
        : ((SHOW_MED > SHOW_HARD) ? SHOW_MED : SHOW_HARD);
    localparam int CW = $clog2(SHOW_MAX + 1);
    localparam logic [7:0] X_MAX   = 8'(MAP_W - 1);
    localparam logic [7:0] Y_MAX   = 8'(MAP_H - 1);
    localparam logic [7:0] START_X8 = 8'(START_X);
    localparam logic [7:0] START_Y8 = 8'(START_Y);
    localparam logic [7:0] GOAL_X8  = 8'(GOAL_X);
    localparam logic [7:0] GOAL_Y8  = 8'(GOAL_Y);

    typedef enum logic [2:0] {PH_MENU, PH_SHOW, PH_PLAY, PH_LOST, PH_WON} phase_t;
    typedef enum logic [1:0] {MV_IDLE, MV_FETCH, MV_CHECK} move_t;

    phase_t r_phase, w_phase_next;
    move_t  r_move,  w_move_next;

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_show_last;
    logic [2:0]    r_menu_sel;
    logic          r_in_instr;
    logic [2:0]    r_difficulty;
    logic [7:0]    r_px, r_py, r_tgt_x, r_tgt_y;
    logic [AW-1:0] r_map_addr;
    logic [7:0]    w_nx, w_ny;
    logic          w_dir_ok, w_accept, w_start, w_wall, w_goal, w_last_life;

    always_comb begin
        case (r_difficulty)
            3'b001:  w_show_last = CW'(SHOW_EASY - 1);
            3'b010:  w_show_last = CW'(SHOW_MED - 1);
            default: w_show_last = CW'(SHOW_HARD - 1);
        endcase
    end

    // Only the highest-priority direction is considered; if it leaves the map the pulse is lost.
    always_comb begin
        w_dir_ok = 1'b0;
        w_nx     = r_px;
        w_ny     = r_py;
        if (i_btn_up) begin
            w_dir_ok = (r_py != 8'd0);
            w_ny     = r_py - 8'd1;
        end else if (i_btn_down) begin
            w_dir_ok = (r_py != Y_MAX);
            w_ny     = r_py + 8'd1;
        end else if (i_btn_left) begin
            w_dir_ok = (r_px != 8'd0);
            w_nx     = r_px - 8'd1;
        end else if (i_btn_right) begin
            w_dir_ok = (r_px != X_MAX);
            w_nx     = r_px + 8'd1;
        end
    end

    assign w_accept = (r_phase == PH_PLAY) && (r_move == MV_IDLE) && w_dir_ok;
    assign w_start  = (r_phase == PH_MENU) && !r_in_instr && i_btn_center && (r_menu_sel == 3'b001);
    // i_map_row holds the row addressed on entry to FETCH by the time the move reaches CHECK.
    assign w_wall   = i_map_row[r_tgt_x[XW-1:0]];
    assign w_goal   = (r_tgt_x == GOAL_X8) && (r_tgt_y == GOAL_Y8);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PH_MENU;
            r_move  <= MV_IDLE;
        end else begin
            r_phase <= w_phase_next;
            r_move  <= w_move_next;
        end
    end

    always_comb begin
        w_phase_next = r_phase;
        w_move_next  = r_move;
        case (r_phase)
            PH_MENU: if (w_start) w_phase_next = PH_SHOW;
            PH_SHOW: if (r_count == w_show_last) w_phase_next = PH_PLAY;
            PH_PLAY: begin
                if (r_move == MV_CHECK) begin
                    if (!w_wall && w_goal)
                        w_phase_next = PH_WON;
                    else if (w_wall && w_last_life)
                        w_phase_next = PH_LOST;
                end
            end
            PH_LOST, PH_WON: if (i_btn_center) w_phase_next = PH_MENU;
            default: w_phase_next = PH_MENU;
        endcase
        case (r_move)
            MV_IDLE:  if (w_accept) w_move_next = MV_FETCH;
            MV_FETCH: w_move_next = MV_CHECK;
            default:  w_move_next = MV_IDLE;
        endcase
    end

    always_comb begin
        case (r_phase)
            PH_MENU:          o_game_state = 4'b0001;
            PH_SHOW, PH_PLAY: o_game_state = 4'b0010;
            PH_LOST:          o_game_state = 4'b0100;
            PH_WON:           o_game_state = 4'b1000;
            default:          o_game_state = 4'b0001;
        endcase
        o_map_visible = (r_phase != PH_PLAY);
        o_dbg_phase   = r_phase;
        o_dbg_move    = r_move;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= '0;
            r_menu_sel   <= 3'b001;
            r_in_instr   <= 1'b0;
            r_difficulty <= 3'b001;
            r_px         <= START_X8;
            r_py         <= START_Y8;
            r_tgt_x      <= '0;
            r_tgt_y      <= '0;
            r_map_addr   <= '0;
        end else begin
            if (r_phase == PH_SHOW && r_count != w_show_last)
                r_count <= r_count + 1'b1;
            else
                r_count <= '0;
            case (r_phase)
                PH_MENU: begin
                    if (r_in_instr) begin
                        if (i_btn_center) r_in_instr <= 1'b0;
                    end else if (i_btn_center) begin
                        case (r_menu_sel)
                            3'b010:  r_difficulty <= {r_difficulty[1:0], r_difficulty[2]};
                            3'b100:  r_in_instr <= 1'b1;
                            default: ;
                        endcase
                    end else if (i_btn_up) begin
                        r_menu_sel <= {r_menu_sel[0], r_menu_sel[2:1]};
                    end else if (i_btn_down) begin
                        r_menu_sel <= {r_menu_sel[1:0], r_menu_sel[2]};
                    end
                end
                PH_PLAY: begin
                    if (w_accept) begin
                        r_tgt_x    <= w_nx;
                        r_tgt_y    <= w_ny;
                        r_map_addr <= w_ny[AW-1:0];
                    end
                    if (r_move == MV_CHECK && !w_wall) begin
                        r_px <= r_tgt_x;
                        r_py <= r_tgt_y;
                    end
                end
                PH_LOST, PH_WON: begin
                    if (i_btn_center) begin
                        r_px       <= START_X8;
                        r_py       <= START_Y8;
                        r_menu_sel <= 3'b001;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MAZE_LIVES_EN
    logic [1:0] r_lives;

    always_ff @(posedge clk) begin
        if (reset)
            r_lives <= 2'(LIVES);
        else if (r_phase == PH_PLAY && r_move == MV_CHECK && w_wall)
            r_lives <= r_lives - 2'd1;
        else if ((r_phase == PH_LOST || r_phase == PH_WON) && i_btn_center)
            r_lives <= 2'(LIVES);
    end

    assign w_last_life  = (r_lives == 2'd1);
    assign o_lives_left = r_lives;
`else
    assign w_last_life  = 1'b1;
    assign o_lives_left = 2'(LIVES);
`endif

    assign o_menu_sel   = r_menu_sel;
    assign o_in_instr   = r_in_instr;
    assign o_difficulty = r_difficulty;
    assign o_player_x   = r_px;
    assign o_player_y   = r_py;
    assign o_map_addr   = r_map_addr;

endmodule

// File: tb/tb_maze_game_sequencer.sv
// Bench for maze_game_sequencer: directed game walkthrough plus randomized play against a
// transaction-level game model; honours MAZE_LIVES_EN.
module tb_maze_game_sequencer;

    localparam int SHOW_E = 8;
    localparam int SHOW_M = 4;
    localparam int SHOW_H = 2;
    localparam int M_MENU = 0, M_SHOW = 1, M_PLAY = 2, M_LOST = 3, M_WON = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;
    logic [4:0]  map_addr;
    logic [29:0] map_row = '0;
    logic [3:0]  game_state;
    logic [2:0]  menu_sel;
    logic        in_instr;
    logic [2:0]  difficulty;
    logic        map_visible;
    logic [7:0]  player_x, player_y;
    logic [1:0]  lives_left;
    logic [2:0]  dbg_phase;
    logic [1:0]  dbg_move;

    logic [29:0] maze [21];

    int checks = 0;
    int errors = 0;

    maze_game_sequencer #(
        .SHOW_EASY(SHOW_E),
        .SHOW_MED (SHOW_M),
        .SHOW_HARD(SHOW_H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_btn_up     (btn_up),
        .i_btn_down   (btn_down),
        .i_btn_left   (btn_left),
        .i_btn_right  (btn_right),
        .i_btn_center (btn_center),
        .o_map_addr   (map_addr),
        .i_map_row    (map_row),
        .o_game_state (game_state),
        .o_menu_sel   (menu_sel),
        .o_in_instr   (in_instr),
        .o_difficulty (difficulty),
        .o_map_visible(map_visible),
        .o_player_x   (player_x),
        .o_player_y   (player_y),
        .o_lives_left (lives_left),
        .o_dbg_phase  (dbg_phase),
        .o_dbg_move   (dbg_move)
    );

    always #5 clk = ~clk;

    // Registered map ROM: row appears one cycle after its address.
    always @(posedge clk) map_row <= (map_addr < 5'd21) ? maze[map_addr] : '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural game model ----------------
    int m_ph, m_sel, m_diff, m_timer, m_busy, m_px, m_py, m_tx, m_ty, m_lives, m_addr;
    bit m_instr;
    bit m_valid = 1'b0;

    function automatic int show_len(input int d);
        return (d == 0) ? SHOW_E : (d == 1) ? SHOW_M : SHOW_H;
    endfunction

    always @(posedge clk) begin
        int dx, dy, nx, ny;
        bit any;
        if (reset) begin
            m_ph = M_MENU; m_sel = 0; m_diff = 0; m_instr = 0; m_timer = 0; m_busy = 0;
            m_px = 0; m_py = 0; m_tx = 0; m_ty = 0; m_lives = 3; m_addr = 0; m_valid = 1'b1;
        end else begin
            case (m_ph)
                M_MENU: begin
                    if (m_instr) begin
                        if (btn_center) m_instr = 0;
                    end else if (btn_center) begin
                        if (m_sel == 0) begin m_ph = M_SHOW; m_timer = show_len(m_diff); end
                        else if (m_sel == 1) m_diff = (m_diff + 1) % 3;
                        else m_instr = 1;
                    end else if (btn_up) m_sel = (m_sel + 2) % 3;
                    else if (btn_down) m_sel = (m_sel + 1) % 3;
                end
                M_SHOW: begin
                    m_timer--;
                    if (m_timer == 0) m_ph = M_PLAY;
                end
                M_PLAY: begin
                    if (m_busy > 0) begin
                        m_busy--;
                        if (m_busy == 0) begin
                            if (maze[m_ty][m_tx] == 1'b0) begin
                                m_px = m_tx; m_py = m_ty;
                                if (m_px == 29 && m_py == 20) m_ph = M_WON;
                            end else begin
`ifdef MAZE_LIVES_EN
                                m_lives--;
                                if (m_lives == 0) m_ph = M_LOST;
`else
                                m_ph = M_LOST;
`endif
                            end
                        end
                    end else begin
                        dx = 0; dy = 0; any = 1;
                        if (btn_up) dy = -1;
                        else if (btn_down) dy = 1;
                        else if (btn_left) dx = -1;
                        else if (btn_right) dx = 1;
                        else any = 0;
                        nx = m_px + dx; ny = m_py + dy;
                        if (any && nx >= 0 && nx <= 29 && ny >= 0 && ny <= 20) begin
                            m_tx = nx; m_ty = ny; m_busy = 2; m_addr = ny;
                        end
                    end
                end
                default: begin
                    if (btn_center) begin
                        m_ph = M_MENU; m_px = 0; m_py = 0; m_lives = 3; m_sel = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("game_state", 32'(game_state),
                  32'((m_ph == M_MENU) ? 1 : (m_ph == M_LOST) ? 4 : (m_ph == M_WON) ? 8 : 2));
            check("menu_sel", 32'(menu_sel), 32'(1 << m_sel));
            check("in_instr", 32'(in_instr), 32'(m_instr));
            check("difficulty", 32'(difficulty), 32'(1 << m_diff));
            check("map_visible", 32'(map_visible), 32'(m_ph != M_PLAY));
            check("player_x", 32'(player_x), 32'(m_px));
            check("player_y", 32'(player_y), 32'(m_py));
            check("lives_left", 32'(lives_left), 32'(m_lives));
            check("map_addr", 32'(map_addr), 32'(m_addr));
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r, input logic c);
        {btn_up, btn_down, btn_left, btn_right, btn_center} = {u, d, l, r, c};
        tick(1);
        {btn_up, btn_down, btn_left, btn_right, btn_center} = 5'b0;
    endtask

    task automatic start_game_hard;
        press(0, 0, 0, 0, 1);
        tick(SHOW_H);
    endtask

    initial begin
        for (int y = 0; y < 21; y++) maze[y] = '0;
        maze[1][2] = 1'b1;
        tick(2);
        reset = 1'b0;
        check("lit_reset_state", 32'(game_state), 32'd1);
        check("lit_reset_sel", 32'(menu_sel), 32'd1);
        check("lit_reset_diff", 32'(difficulty), 32'd1);
        check("lit_reset_vis", 32'(map_visible), 32'd1);
        check("lit_reset_lives", 32'(lives_left), 32'd3);

        press(0, 1, 0, 0, 0);
        check("lit_menu_down", 32'(menu_sel), 32'b010);
        press(0, 0, 0, 0, 1);
        check("lit_diff_med", 32'(difficulty), 32'b010);
        press(0, 0, 0, 0, 1);
        check("lit_diff_hard", 32'(difficulty), 32'b100);
        press(1, 0, 0, 0, 0);
        check("lit_menu_up", 32'(menu_sel), 32'b001);
        press(0, 0, 0, 0, 1);
        check("lit_enter_game", 32'(game_state), 32'b0010);
        tick(1);
        check("lit_show_vis", 32'(map_visible), 32'd1);
        tick(1);
        check("lit_play_hidden", 32'(map_visible), 32'd0);

        press(0, 0, 1, 0, 0);
        tick(3);
        check("lit_left_edge_x", 32'(player_x), 32'd0);
        press(1, 0, 0, 1, 0);
        tick(3);
        check("lit_up_wins_dropped", 32'(player_x), 32'd0);
        press(0, 0, 0, 1, 0);
        check("lit_fetch_addr", 32'(map_addr), 32'd0);
        tick(1);
        check("lit_no_early_move", 32'(player_x), 32'd0);
        tick(1);
        check("lit_moved_right", 32'(player_x), 32'd1);
        press(0, 1, 0, 0, 0);
        check("lit_fetch_addr_row1", 32'(map_addr), 32'd1);
        tick(2);
        check("lit_moved_down", 32'(player_y), 32'd1);

        press(0, 0, 0, 1, 0);
        tick(2);
`ifdef MAZE_LIVES_EN
        check("lit_lives_2", 32'(lives_left), 32'd2);
        check("lit_still_game", 32'(game_state), 32'b0010);
        press(0, 0, 0, 1, 0);
        tick(2);
        check("lit_lives_1", 32'(lives_left), 32'd1);
        press(0, 0, 0, 1, 0);
        tick(2);
        check("lit_lives_0", 32'(lives_left), 32'd0);
`endif
        check("lit_lost", 32'(game_state), 32'b0100);
        check("lit_wall_no_move", 32'(player_x), 32'd1);
        press(0, 0, 0, 0, 1);
        check("lit_back_menu", 32'(game_state), 32'b0001);
        check("lit_back_start_x", 32'(player_x), 32'd0);
        check("lit_back_start_y", 32'(player_y), 32'd0);

        start_game_hard();
        for (int i = 0; i < 29; i++) begin press(0, 0, 0, 1, 0); tick(2); end
        for (int i = 0; i < 20; i++) begin press(0, 1, 0, 0, 0); tick(2); end
        check("lit_won", 32'(game_state), 32'b1000);
        press(0, 0, 1, 0, 0);
        tick(3);
        check("lit_won_frozen", 32'(player_x), 32'd29);
        press(0, 0, 0, 0, 1);

        start_game_hard();
        press(0, 0, 0, 1, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("lit_reset_mid_move", 32'(game_state), 32'b0001);
        tick(3);
        check("lit_reset_no_update", 32'(player_x), 32'd0);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [4:0] b;
            if (m_ph == M_MENU && $urandom_range(0, 19) == 0) begin
                for (int y = 0; y < 21; y++) maze[y] = 30'($urandom & $urandom);
                maze[0][0] = 1'b0;
            end
            reset = ($urandom_range(0, 599) == 0);
            b = '0;
            if (m_ph == M_MENU) begin
                case ($urandom_range(0, 7))
                    0: b[4] = 1'b1;
                    1: b[3] = 1'b1;
                    2: b[0] = 1'b1;
                    3: b[2] = 1'b1;
                    default: ;
                endcase
            end else begin
                b[4] = ($urandom_range(0, 2) == 0);
                b[3] = ($urandom_range(0, 2) == 0);
                b[2] = ($urandom_range(0, 2) == 0);
                b[1] = ($urandom_range(0, 2) == 0);
                b[0] = ($urandom_range(0, 4) == 0);
            end
            {btn_up, btn_down, btn_left, btn_right, btn_center} = b;
            tick(1);
        end
        {btn_up, btn_down, btn_left, btn_right, btn_center} = 5'b0;
        reset = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
